register_dump: RTL and testbench
================================

# register_dump

Sequenced reader for the register block's two combinational read ports. On a `start` pulse it sweeps registers 0..NUM_REGS-1 two at a time, captures `read_data1`/`read_data2`, and streams each word out over a valid/ready handshake tagged with its register index. It sits beside the register block as a debug/context-save port. It holds off register-block writes via `hold` for the duration of the sweep.

## Interface
- `NUM_REGS`, default 32: registers swept. Must be even, 2..32. Other values are a compile-time error.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: sweep request, sampled on the rising edge. Ignored while `busy`=1.
- `read_reg1` output 5: address to register block read port 1, even register of the pair.
- `read_reg2` output 5: address to register block read port 2, odd register of the pair.
- `read_data1` input 32: data from read port 1, combinational on `read_reg1`.
- `read_data2` input 32: data from read port 2, combinational on `read_reg2`.
- `hold` output 1: equal to `busy`. Write-side logic must keep `regWrite`=0 while it is high.
- `busy` output 1: sweep in progress.
- `done` output 1: one-cycle pulse when a sweep completes.
- `out_data` output 32: streamed word.
- `out_idx` output 5: register index of `out_data`.
- `out_last` output 1: marks the final word of the sweep.
- `out_valid` output 1: `out_data`/`out_idx`/`out_last` are valid.
- `out_ready` input 1: consumer accepts the word. A transfer occurs when `out_valid`=1 and `out_ready`=1 on a rising edge.

## Operation
- States:
  - IDLE: `read_reg1`/`read_reg2` = 0. `start`=1 → FETCH, with `idx`=0 and `busy`=1.
  - FETCH: drive `read_reg1`=`idx` and `read_reg2`=`idx`+1. Latch `read_data1` into A and `read_data2` into B at the end of the cycle. Always goes to SEND_A next; takes exactly 1 cycle.
  - SEND_A: `out_valid`=1, `out_data`=A, `out_idx`=`idx`. On transfer → SEND_B.
  - SEND_B: `out_valid`=1, `out_data`=B, `out_idx`=`idx`+1. On transfer:
    - if `idx`+2 < NUM_REGS: `idx`+=2 → FETCH;
    - otherwise → DONE, or → CHK when the checksum is configured.
  - DONE: `done`=1 and `busy`=0 for this one cycle; `out_valid`=0. Always → IDLE.
- `idx` is 5 bits. It never wraps, because NUM_REGS ≤ 32 and the last pair starts at NUM_REGS-2.
- `read_reg1`/`read_reg2` hold their pair addresses through SEND_A and SEND_B. Only the FETCH capture is used.
- While `out_valid`=1 and `out_ready`=0, all `out_*` outputs stay stable. `out_valid` never drops without a transfer, except on reset.
- `out_last`=1 only on the final word: register NUM_REGS-1, or the checksum word when it is configured.
- `start` is ignored in every state except IDLE. A `start` in the DONE cycle is dropped.

## Timing
- Reset values:
  - `read_reg1`, `read_reg2`, `out_data`, `out_idx` = 0;
  - `out_valid`, `out_last`, `busy`, `hold`, `done` = 0;
  - state = IDLE, A = B = 0.
- Reset wins over every other condition. `rst_n`=0 mid-sweep puts the block in IDLE on that edge: `out_valid` drops and no `done` pulse is produced.
- With `start` sampled at edge k:
  - FETCH in cycle k+1, with `busy`=1 in cycle k+1;
  - first `out_valid` in cycle k+2.
- With `out_ready` held at 1, each pair takes 3 cycles. NUM_REGS=32 gives 48 cycles from FETCH to the last transfer, then 1 DONE cycle.
- Each stalled cycle with `out_ready`=0 adds exactly one cycle.
- `busy` falls in the DONE cycle, together with the `done` pulse.

## Configuration
- `REGDUMP_CHECKSUM_EN` defined:
  - after the SEND_B of the last pair, state CHK emits one extra word: `out_data` = 32-bit wrapping sum of all NUM_REGS words, `out_idx`=0, `out_last`=1;
  - on transfer → DONE;
  - the accumulator clears when FETCH is entered from IDLE.
- Not defined: CHK state and accumulator are absent, and `out_last` is marked on register NUM_REGS-1.

## Test plan
- Basic sweep:
  - stimulus: bench register model holds r_i = 0x100+i, `out_ready`=1, pulse `start`;
  - response: 32 transfers, `out_idx` 0..31 in order with `out_data` 0x100+i; `out_last` only on idx 31; `done` one cycle after the last transfer; 48 cycles from FETCH to the last transfer.
- Backpressure:
  - stimulus: same register contents, `out_ready` low for 3 cycles during SEND_A of idx 4;
  - response: `out_data`=0x104 and `out_idx`=4 held stable throughout; total time is +3 cycles.
- Start while busy:
  - stimulus: a second `start` at word idx 10, and another in the DONE cycle;
  - response: both are ignored; exactly 32 words and one `done`.
- Reset mid-operation:
  - stimulus: `rst_n`=0 for one cycle at idx 16;
  - response: next cycle `out_valid`=0, `busy`=0, addresses 0, no `done`; a following `start` restarts the sweep at idx 0.
- NUM_REGS=2:
  - stimulus: r0=0, r1=0xDEADBEEF;
  - response: two words, `out_last` on idx 1, `done` 1 cycle after.
- `REGDUMP_CHECKSUM_EN` defined:
  - stimulus: r_i = 0x100+i, basic sweep;
  - response: 33rd word is 0x000021F0, with `out_idx`=0 and `out_last`=1; `out_last`=0 on idx 31.

Source files
------------

// File: rtl/register_dump.sv
// -----------------------------------------------------------------------------
// register_dump
//
// Sequenced reader for the register block's two combinational read ports.
// A start pulse sweeps registers 0..NUM_REGS-1 two at a time. Each pair is
// captured from read_data1/read_data2, then streamed out one word at a time
// over a valid/ready handshake, tagged with its register index. hold (equal
// to busy) tells the write-side logic to keep regWrite low during the sweep.
//
// Optional feature macro: REGDUMP_CHECKSUM_EN
//   When defined, one extra word follows the last register. It carries the
//   32-bit wrapping sum of all swept words, with out_idx = 0 and out_last = 1.
//   When undefined, out_last marks register NUM_REGS-1.
//
// Parameters
//   NUM_REGS   registers swept; must be even and in 2..32
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   start       in   sweep request; only honoured in IDLE
//   read_reg1   out  [4:0]  read port 1 address (even register of the pair)
//   read_reg2   out  [4:0]  read port 2 address (odd register of the pair)
//   read_data1  in   [31:0] read port 1 data, combinational on read_reg1
//   read_data2  in   [31:0] read port 2 data, combinational on read_reg2
//   hold        out  write hold-off for the register block (== busy)
//   busy        out  sweep in progress
//   done        out  one-cycle pulse when a sweep completes
//   out_data    out  [31:0] streamed word
//   out_idx     out  [4:0]  register index of out_data
//   out_last    out  final word of the sweep
//   out_valid   out  out_data/out_idx/out_last are valid
//   out_ready   in   consumer accepts the word
// -----------------------------------------------------------------------------
module register_dump #(
   parameter int NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [4:0]  read_reg1,
   output logic [4:0]  read_reg2,
   input  logic [31:0] read_data1,
   input  logic [31:0] read_data2,
   output logic        hold,
   output logic        busy,
   output logic        done,
   output logic [31:0] out_data,
   output logic [4:0]  out_idx,
   output logic        out_last,
   output logic        out_valid,
   input  logic        out_ready
);

   if ((NUM_REGS < 2) || (NUM_REGS > 32) || ((NUM_REGS % 2) != 0)) begin : g_bad_num_regs
      $error("register_dump: NUM_REGS must be even and in 2..32");
   end

   // Start index of the final pair; idx equal to this means idx+2 >= NUM_REGS.
   localparam logic [4:0] LAST_PAIR = 5'(NUM_REGS - 2);

`ifdef REGDUMP_CHECKSUM_EN
   localparam logic LAST_ON_REG = 1'b0;
`else
   localparam logic LAST_ON_REG = 1'b1;
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_SEND_A = 3'd2,
      S_SEND_B = 3'd3,
      S_DONE   = 3'd4,
      S_CHK    = 3'd5
   } state_t;

   state_t      state;
   logic [4:0]  idx;
   logic [31:0] word_b;
   logic        last_pair;
   logic        xfer;

`ifdef REGDUMP_CHECKSUM_EN
   logic [31:0] csum;
`endif

   assign last_pair = (idx == LAST_PAIR);
   assign xfer      = out_valid & out_ready;
   assign hold      = busy;

   // out_data doubles as the A capture register: it is loaded from read_data1
   // at the end of FETCH and shown unchanged throughout SEND_A.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         idx       <= '0;
         word_b    <= '0;
         read_reg1 <= '0;
         read_reg2 <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_FETCH;
                  idx       <= 5'd0;
                  read_reg1 <= 5'd0;
                  read_reg2 <= 5'd1;
                  busy      <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                  csum      <= '0;
`endif
               end
            end

            // Addresses were set up on entry, so the read ports are settled
            // here; capture both words and present the even one.
            S_FETCH: begin
               word_b    <= read_data2;
               out_data  <= read_data1;
               out_idx   <= idx;
               out_last  <= 1'b0;
               out_valid <= 1'b1;
               state     <= S_SEND_A;
`ifdef REGDUMP_CHECKSUM_EN
               csum      <= csum + read_data1 + read_data2;
`endif
            end

            S_SEND_A: begin
               if (xfer) begin
                  out_data <= word_b;
                  out_idx  <= idx + 5'd1;
                  out_last <= last_pair & LAST_ON_REG;
                  state    <= S_SEND_B;
               end
            end

            S_SEND_B: begin
               if (xfer) begin
                  if (!last_pair) begin
                     idx       <= idx + 5'd2;
                     read_reg1 <= idx + 5'd2;
                     read_reg2 <= idx + 5'd3;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     state     <= S_FETCH;
                  end else begin
`ifdef REGDUMP_CHECKSUM_EN
                     out_data  <= csum;
                     out_idx   <= 5'd0;
                     out_last  <= 1'b1;
                     state     <= S_CHK;
`else
                     read_reg1 <= '0;
                     read_reg2 <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= S_DONE;
`endif
                  end
               end
            end

`ifdef REGDUMP_CHECKSUM_EN
            S_CHK: begin
               if (xfer) begin
                  read_reg1 <= '0;
                  read_reg2 <= '0;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= S_DONE;
               end
            end
`endif

            // start is deliberately not looked at here: a request landing in
            // the completion cycle is dropped.
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               state     <= S_IDLE;
               busy      <= 1'b0;
               done      <= 1'b0;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               read_reg1 <= '0;
               read_reg2 <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_register_dump.sv
module tb_register_dump;

`ifdef REGDUMP_CHECKSUM_EN
   localparam int CKS = 1;
`else
   localparam int CKS = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;

   // 32-register instance
   logic        start;
   logic [4:0]  read_reg1, read_reg2;
   logic [31:0] read_data1, read_data2;
   logic        hold, busy, done;
   logic [31:0] out_data;
   logic [4:0]  out_idx;
   logic        out_last, out_valid, out_ready;

   // 2-register instance
   logic        s2_start;
   logic [4:0]  s2_read_reg1, s2_read_reg2;
   logic [31:0] s2_read_data1, s2_read_data2;
   logic        s2_hold, s2_busy, s2_done;
   logic [31:0] s2_out_data;
   logic [4:0]  s2_out_idx;
   logic        s2_out_last, s2_out_valid, s2_out_ready;

   logic [31:0] regs  [32];
   logic [31:0] regs2 [32];

   assign read_data1    = regs[read_reg1];
   assign read_data2    = regs[read_reg2];
   assign s2_read_data1 = regs2[s2_read_reg1];
   assign s2_read_data2 = regs2[s2_read_reg2];

   register_dump #(.NUM_REGS(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .read_reg1(read_reg1), .read_reg2(read_reg2),
      .read_data1(read_data1), .read_data2(read_data2),
      .hold(hold), .busy(busy), .done(done),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   register_dump #(.NUM_REGS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(s2_start),
      .read_reg1(s2_read_reg1), .read_reg2(s2_read_reg2),
      .read_data1(s2_read_data1), .read_data2(s2_read_data2),
      .hold(s2_hold), .busy(s2_busy), .done(s2_done),
      .out_data(s2_out_data), .out_idx(s2_out_idx), .out_last(s2_out_last),
      .out_valid(s2_out_valid), .out_ready(s2_out_ready)
   );

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Expected stream word w: registers hold 0x100+i; word 32 is the checksum.
   function automatic logic [31:0] exp_data(input int w);
      if (w < 32) return 32'h100 + 32'(w);
      return 32'h0000_21F0;
   endfunction

   function automatic logic [31:0] exp_idx(input int w);
      if (w < 32) return 32'(w);
      return 32'd0;
   endfunction

   function automatic logic [31:0] exp_last(input int w);
      if (w == 32) return 32'd1;
      if (w == 31 && CKS == 0) return 32'd1;
      return 32'd0;
   endfunction

   // One full sweep of the 32-register instance, observed at negedges.
   task automatic do_sweep(input int stall_at, input int stall_n, input bit poke);
      int w = 0, cyc = 0, stalled = 0, dones = 0;
      int last_cyc = -1, done_cyc = -1;
      int total = 32 + CKS;
      bit poked = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("fetch_busy",  32'(busy), 32'd1);
      chk("fetch_hold",  32'(hold), 32'd1);
      chk("fetch_valid", 32'(out_valid), 32'd0);
      chk("fetch_rr1",   32'(read_reg1), 32'd0);
      chk("fetch_rr2",   32'(read_reg2), 32'd1);
      for (int t = 0; t < 300 && done_cyc < 0; t++) begin
         start = 1'b0;
         out_ready = 1'b1;
         if (out_valid) begin
            chk($sformatf("idx_w%0d", w),  32'(out_idx), exp_idx(w));
            chk($sformatf("data_w%0d", w), out_data, exp_data(w));
            chk($sformatf("last_w%0d", w), 32'(out_last), exp_last(w));
            if (w < 32) chk($sformatf("rr1_w%0d", w), 32'(read_reg1), 32'(w & ~1));
            if (poke && !poked && w == 10) begin
               start = 1'b1;
               poked = 1'b1;
            end
            if (w == stall_at && stalled < stall_n) begin
               out_ready = 1'b0;
               stalled++;
            end else begin
               w++;
               if (w == total) last_cyc = cyc;
            end
         end
         if (done) begin
            dones++;
            done_cyc = cyc;
            chk("done_busy", 32'(busy), 32'd0);
            if (poke) start = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      for (int t = 0; t < 4; t++) begin
         if (done) dones++;
         chk("post_busy",  32'(busy), 32'd0);
         chk("post_valid", 32'(out_valid), 32'd0);
         @(negedge clk);
      end
      chk("word_count", 32'(w), 32'(total));
      chk("last_xfer_cycle", 32'(last_cyc), 32'(47 + stall_n + CKS));
      chk("done_cycle", 32'(done_cyc), 32'(last_cyc + 1));
      chk("done_count", 32'(dones), 32'd1);
   endtask

   task automatic reset_mid;
      int dones = 0;
      bit hit = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int t = 0; t < 100 && !hit; t++) begin
         if (out_valid && out_idx == 5'd16) hit = 1'b1;
         else @(negedge clk);
      end
      chk("rst_reached_16", 32'(hit), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_rr1",   32'(read_reg1), 32'd0);
      chk("rst_rr2",   32'(read_reg2), 32'd0);
      for (int t = 0; t < 6; t++) begin
         if (done) dones++;
         @(negedge clk);
      end
      chk("rst_no_done", 32'(dones), 32'd0);
   endtask

   task automatic sweep2;
      int w = 0, cyc = 0, last_cyc = -1, done_cyc = -1;
      int total = 2 + CKS;
      logic [31:0] d;
      @(negedge clk) s2_start = 1'b1;
      @(negedge clk) s2_start = 1'b0;
      chk("s2_fetch_busy", 32'(s2_busy), 32'd1);
      for (int t = 0; t < 20 && done_cyc < 0; t++) begin
         if (s2_out_valid) begin
            d = (w == 0) ? 32'h0 : 32'hDEAD_BEEF;
            chk($sformatf("s2_idx_w%0d", w),  32'(s2_out_idx), (w == 1) ? 32'd1 : 32'd0);
            chk($sformatf("s2_data_w%0d", w), s2_out_data, d);
            chk($sformatf("s2_last_w%0d", w), 32'(s2_out_last),
                (w == total - 1) ? 32'd1 : 32'd0);
            w++;
            if (w == total) last_cyc = cyc;
         end
         if (s2_done) done_cyc = cyc;
         @(negedge clk);
         cyc++;
      end
      chk("s2_word_count", 32'(w), 32'(total));
      chk("s2_last_cycle", 32'(last_cyc), 32'(2 + CKS));
      chk("s2_done_cycle", 32'(done_cyc), 32'(last_cyc + 1));
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         regs[i]  = 32'h100 + 32'(i);
         regs2[i] = 32'h0;
      end
      regs2[1]     = 32'hDEAD_BEEF;
      rst_n        = 1'b0;
      start        = 1'b0;
      out_ready    = 1'b1;
      s2_start     = 1'b0;
      s2_out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last",  32'(out_last), 32'd0);
      chk("rst_busy0",     32'(busy), 32'd0);
      chk("rst_hold0",     32'(hold), 32'd0);
      chk("rst_done0",     32'(done), 32'd0);
      chk("rst_out_data",  out_data, 32'd0);
      chk("rst_out_idx",   32'(out_idx), 32'd0);
      chk("rst_rr1_0",     32'(read_reg1), 32'd0);
      chk("rst_rr2_0",     32'(read_reg2), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_sweep(-1, 0, 1'b0);   // basic sweep
      do_sweep(4, 3, 1'b0);    // backpressure on SEND_A of idx 4
      do_sweep(-1, 0, 1'b1);   // start while busy and in DONE
      reset_mid();
      do_sweep(-1, 0, 1'b0);   // restart after reset
      sweep2();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
